wb_snoop_responder: RTL and testbench
=====================================

# wb_snoop_responder

Per-core snoop responder in the multi-core Wishbone interconnect, downstream of `wb_snoop_arbiter`. One instance per core.
- Consumes this core's lane of the arbiter's `snoop_adr_o` and its shared `snoop_type_o`.
- Queries or invalidates the core's write-back data cache through a request/ack lookup port.
- Returns the 2-bit poll response and snooped data that feed the arbiter's `snoop_response_i` / `snooped_dat_i` lane for this core.

## Interface
Parameters:
- aw, 32, address width
- dw, 32, data width
- TIMEOUT, 16, max cycles `cache_req_o` may wait for ack (≥1); counter width `$clog2(TIMEOUT+1)`

Ports:
- wb_clk_i  in  1  clock; one clock; all logic on rising edge
- wb_rst_i  in  1  reset; asynchronous, active-high
- snoop_adr_i  in  aw  snooped address (this core's lane)
- snoop_type_i  in  2  00 IDLE, 01 READ, 10 WRITE, 11 unused
- snoop_self_i  in  1  this core is the current bus requester
- snoop_response_o  out  2  10 UNDEFINED, 11 POSITIVE, 00 NEGATIVE
- snooped_dat_o  out  dw  data returned on positive READ
- cache_req_o  out  1  lookup/invalidate request
- cache_inv_o  out  1  qualifies `cache_req_o` as invalidate (1) or lookup (0)
- cache_adr_o  out  aw  address for the cache request
- cache_ack_i  in  1  cache completed request; `cache_hit_i`, `cache_dirty_i`, `cache_dat_i` valid this cycle
- cache_hit_i  in  1  line present
- cache_dirty_i  in  1  line modified
- cache_dat_i  in  dw  line word at `cache_adr_o`

## Operation
States (one-hot): IDLE, LOOKUP, INVAL, HOLD.
- Reset values: state IDLE, `snoop_response_o`=10, `snooped_dat_o`=0, `cache_req_o`=0, `cache_inv_o`=0, `cache_adr_o`=0, timeout counter 0.
- IDLE: response 10, data 0.
  - type 01 and `snoop_self_i`=1 → HOLD with NEGATIVE; no cache request.
  - type 01, not self → latch `snoop_adr_i` into `cache_adr_o`, raise `cache_req_o` (inv=0), → LOOKUP.
  - type 10, not self → latch address, raise `cache_req_o` with inv=1, → INVAL.
  - type 10, self → HOLD with NEGATIVE.
  - type 11 → ignored, stay IDLE.
- LOOKUP: `cache_req_o` and `cache_adr_o` held stable until ack or timeout.
  - ack with hit=1 and dirty=1 → response 11, data ← `cache_dat_i`.
  - ack otherwise → response 00.
  - Either way drop req → HOLD.
- INVAL: same handshake.
  - ack with hit=1 → response 11; hit=0 → 00.
  - Data stays 0. The cache clears the line on the acked cycle.
- Timeout: counter increments each cycle req is high without ack. On reaching TIMEOUT, drop req, response 00, → HOLD. Ack on the timeout cycle takes priority over timeout.
- HOLD: response and data held stable until `snoop_type_i`=00, then → IDLE with response 10 and data 0.
- Abort: `snoop_type_i` returning to 00 during LOOKUP/INVAL does not withdraw the request.
  - Handshake completes by ack or timeout.
  - Result is discarded; state → IDLE directly with response 10.
  - An invalidate already issued is still performed.
- `snoop_type_i` changing between 01 and 10 while busy is ignored; the latched operation completes.
- Async reset mid-operation: all outputs return to reset values immediately; outstanding request abandoned.

## Timing
- Cycle 0: type sampled non-idle in IDLE. Cycle 1: `cache_req_o` high (or self: response 00 valid).
- Ack sampled in cycle k → response/data valid from cycle k+1; req low in cycle k+1.
- Minimum latency type→response: 1 cycle (self), 2 cycles (ack in cycle 1).
- Timeout: req high for exactly TIMEOUT cycles without ack → response 00 in the following cycle.
- Type sampled 00 in HOLD at cycle m → response 10 at cycle m+1. A new request is accepted from cycle m+1 sampling, with no back-to-back overlap.

## Test plan
- READ hit dirty: addr 0x100, ack after 3 cycles with hit=1 dirty=1 dat=0xDEADBEEF → response 11, data 0xDEADBEEF held until type 00, then 10/0.
- READ hit clean: ack with hit=1 dirty=0 → response 00, data 0.
- READ with `snoop_self_i`=1 → response 00 one cycle after type 01; `cache_req_o` never asserted.
- WRITE: addr 0x200, ack hit=1 → `cache_inv_o`=1 with req, response 11. Repeat with hit=0 → 00.
- Timeout: TIMEOUT=4, no ack → req high exactly 4 cycles, then response 00. Ack on the 4th cycle → ack result used.
- Abort and reset: type → 00 during LOOKUP, then ack → response stays 10, back to IDLE. Assert `wb_rst_i` mid-LOOKUP → req 0 and response 10 without a clock edge.

Source files
------------

// File: rtl/wb_snoop_responder_if.sv
// Snoop lane between the snoop arbiter and one core's responder, plus the
// request/ack lookup port into that core's write-back data cache.
interface wb_snoop_responder_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0] snoop_adr_i;
  logic [1:0]    snoop_type_i;
  logic          snoop_self_i;
  logic [1:0]    snoop_response_o;
  logic [dw-1:0] snooped_dat_o;
  logic          cache_req_o;
  logic          cache_inv_o;
  logic [aw-1:0] cache_adr_o;
  logic          cache_ack_i;
  logic          cache_hit_i;
  logic          cache_dirty_i;
  logic [dw-1:0] cache_dat_i;

  // Responder side.
  modport slave (
    input  snoop_adr_i, snoop_type_i, snoop_self_i,
    input  cache_ack_i, cache_hit_i, cache_dirty_i, cache_dat_i,
    output snoop_response_o, snooped_dat_o,
    output cache_req_o, cache_inv_o, cache_adr_o
  );

  // Arbiter / cache side.
  modport master (
    output snoop_adr_i, snoop_type_i, snoop_self_i,
    output cache_ack_i, cache_hit_i, cache_dirty_i, cache_dat_i,
    input  snoop_response_o, snooped_dat_o,
    input  cache_req_o, cache_inv_o, cache_adr_o
  );
endinterface

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder: turns a snoop READ/WRITE into a cache lookup or
// invalidate, then returns the poll response (and dirty data on a READ hit)
// until the arbiter drops the snoop type back to IDLE.
module wb_snoop_responder #(
  parameter int aw      = 32,
  parameter int dw      = 32,
  parameter int TIMEOUT = 16
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  wb_snoop_responder_if.slave bus
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] TYPE_IDLE  = 2'b00;
  localparam logic [1:0] TYPE_READ  = 2'b01;
  localparam logic [1:0] TYPE_WRITE = 2'b10;

  localparam logic [1:0] RESP_UNDEF = 2'b10;
  localparam logic [1:0] RESP_POS   = 2'b11;
  localparam logic [1:0] RESP_NEG   = 2'b00;

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_LOOKUP = 4'b0010,
    S_INVAL  = 4'b0100,
    S_HOLD   = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    resp_q, resp_d;
  logic [dw-1:0] dat_q, dat_d;
  logic          req_q, req_d;
  logic          inv_q, inv_d;
  logic [aw-1:0] adr_q, adr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;

  logic busy;
  logic is_rw;
  logic abort_now;
  logic timed_out;
  logic done;

  // Handshake status shared by the next-state and output logic.
  always_comb begin
    busy      = (state_q == S_LOOKUP) || (state_q == S_INVAL);
    is_rw     = (bus.snoop_type_i == TYPE_READ) || (bus.snoop_type_i == TYPE_WRITE);
    // An abort seen on any busy cycle, including the completing one, discards the result.
    abort_now = abort_q || (bus.snoop_type_i == TYPE_IDLE);
    // Ack on the last allowed cycle wins over the timeout.
    timed_out = !bus.cache_ack_i && (cnt_q == CNT_LAST);
    done      = busy && (bus.cache_ack_i || timed_out);
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      resp_q  <= RESP_UNDEF;
      dat_q   <= '0;
      req_q   <= 1'b0;
      inv_q   <= 1'b0;
      adr_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      inv_q   <= inv_d;
      adr_q   <= adr_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_rw) begin
          if (bus.snoop_self_i)                     state_d = S_HOLD;
          else if (bus.snoop_type_i == TYPE_READ)   state_d = S_LOOKUP;
          else                                      state_d = S_INVAL;
        end
      end
      S_LOOKUP, S_INVAL: begin
        if (done) state_d = abort_now ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (bus.snoop_type_i == TYPE_IDLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    resp_d  = resp_q;
    dat_d   = dat_q;
    req_d   = req_q;
    inv_d   = inv_q;
    adr_d   = adr_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    unique case (state_q)
      S_IDLE: begin
        resp_d  = RESP_UNDEF;
        dat_d   = '0;
        cnt_d   = '0;
        abort_d = 1'b0;
        if (is_rw) begin
          if (bus.snoop_self_i) begin
            resp_d = RESP_NEG;
          end else begin
            req_d = 1'b1;
            inv_d = (bus.snoop_type_i == TYPE_WRITE);
            adr_d = bus.snoop_adr_i;
          end
        end
      end
      S_LOOKUP, S_INVAL: begin
        if (done) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (abort_now) begin
            resp_d = RESP_UNDEF;
            dat_d  = '0;
          end else if (!bus.cache_ack_i) begin
            resp_d = RESP_NEG;
          end else if (state_q == S_LOOKUP) begin
            // Only a dirty line needs supplying; a clean hit is served by memory.
            if (bus.cache_hit_i && bus.cache_dirty_i) begin
              resp_d = RESP_POS;
              dat_d  = bus.cache_dat_i;
            end else begin
              resp_d = RESP_NEG;
            end
          end else begin
            resp_d = bus.cache_hit_i ? RESP_POS : RESP_NEG;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          abort_d = abort_now;
        end
      end
      S_HOLD: begin
        if (bus.snoop_type_i == TYPE_IDLE) begin
          resp_d = RESP_UNDEF;
          dat_d  = '0;
        end
      end
      default: begin
        resp_d  = RESP_UNDEF;
        dat_d   = '0;
        req_d   = 1'b0;
        cnt_d   = '0;
        abort_d = 1'b0;
      end
    endcase
  end

  assign bus.snoop_response_o = resp_q;
  assign bus.snooped_dat_o    = dat_q;
  assign bus.cache_req_o      = req_q;
  assign bus.cache_inv_o      = inv_q;
  assign bus.cache_adr_o      = adr_q;

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench for wb_snoop_responder with a response scoreboard.
module tb_wb_snoop_responder;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_snoop_responder_if #(.aw(32), .dw(32)) bus ();

  wb_snoop_responder #(.aw(32), .dw(32), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.snoop_adr_i   = '0;
    bus.snoop_type_i  = 2'b00;
    bus.snoop_self_i  = 1'b0;
    bus.cache_ack_i   = 1'b0;
    bus.cache_hit_i   = 1'b0;
    bus.cache_dirty_i = 1'b0;
    bus.cache_dat_i   = 32'h0BAD_F00D;
  endtask

  // Drive a snoop, record the expected outcome, advance into cycle 1.
  task automatic issue(input logic [1:0] typ, input logic [31:0] adr, input logic self,
                       input logic [1:0] er, input logic [31:0] ed);
    bus.snoop_type_i = typ;
    bus.snoop_adr_i  = adr;
    bus.snoop_self_i = self;
    exp_q.push_back('{resp: er, dat: ed});
    step();
  endtask

  // Cache model: acks on the ack_at-th cycle of req (0 = never); returns req-high cycle count.
  task automatic serve(input string tag, input int ack_at, input logic hit, input logic dirty,
                       input logic [31:0] dat, input logic exp_inv, input logic [31:0] exp_adr,
                       output int nreq);
    nreq = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.cache_req_o) break;
      nreq++;
      check({tag, "_inv"}, bus.cache_inv_o, exp_inv);
      check({tag, "_adr"}, bus.cache_adr_o, exp_adr);
      if (nreq == ack_at) begin
        bus.cache_ack_i   = 1'b1;
        bus.cache_hit_i   = hit;
        bus.cache_dirty_i = dirty;
        bus.cache_dat_i   = dat;
      end
      step();
      bus.cache_ack_i   = 1'b0;
      bus.cache_hit_i   = 1'b0;
      bus.cache_dirty_i = 1'b0;
      bus.cache_dat_i   = 32'h0BAD_F00D;
    end
  endtask

  task automatic check_result(input string tag, output exp_t e);
    if (exp_q.size() == 0) begin
      e = '{resp: 2'b10, dat: 32'h0};
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_resp"}, bus.snoop_response_o, e.resp);
    check({tag, "_dat"}, bus.snooped_dat_o, e.dat);
  endtask

  // Response must stay put until the type returns to IDLE, then clear.
  task automatic hold_release(input string tag, input exp_t e);
    for (int i = 0; i < 2; i++) begin
      step();
      check({tag, "_hold_resp"}, bus.snoop_response_o, e.resp);
      check({tag, "_hold_dat"}, bus.snooped_dat_o, e.dat);
      check({tag, "_hold_req"}, bus.cache_req_o, 1'b0);
    end
    bus.snoop_type_i = 2'b00;
    step();
    check({tag, "_rel_resp"}, bus.snoop_response_o, 2'b10);
    check({tag, "_rel_dat"}, bus.snooped_dat_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   nreq;

    idle_inputs();
    rst = 1'b1;
    #3;
    check("rst_resp", bus.snoop_response_o, 2'b10);
    check("rst_dat", bus.snooped_dat_o, 32'h0);
    check("rst_req", bus.cache_req_o, 1'b0);
    check("rst_inv", bus.cache_inv_o, 1'b0);
    check("rst_adr", bus.cache_adr_o, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("idle_resp", bus.snoop_response_o, 2'b10);

    // READ hit dirty; type flips to WRITE mid-lookup and must be ignored.
    issue(2'b01, 32'h100, 1'b0, 2'b11, 32'hDEAD_BEEF);
    check("rd_dirty_req", bus.cache_req_o, 1'b1);
    bus.snoop_type_i = 2'b10;
    serve("rd_dirty", 3, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h100, nreq);
    check("rd_dirty_nreq", 64'(nreq), 64'd3);
    check_result("rd_dirty", e);
    hold_release("rd_dirty", e);

    // READ hit clean.
    issue(2'b01, 32'h104, 1'b0, 2'b00, 32'h0);
    serve("rd_clean", 2, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 32'h104, nreq);
    check("rd_clean_nreq", 64'(nreq), 64'd2);
    check_result("rd_clean", e);
    hold_release("rd_clean", e);

    // READ by the requesting core itself.
    issue(2'b01, 32'h108, 1'b1, 2'b00, 32'h0);
    check("rd_self_req", bus.cache_req_o, 1'b0);
    check_result("rd_self", e);
    hold_release("rd_self", e);

    // WRITE hit, acked in cycle 1 (minimum latency).
    issue(2'b10, 32'h200, 1'b0, 2'b11, 32'h0);
    check("wr_hit_req", bus.cache_req_o, 1'b1);
    serve("wr_hit", 1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h200, nreq);
    check("wr_hit_nreq", 64'(nreq), 64'd1);
    check_result("wr_hit", e);
    hold_release("wr_hit", e);

    // WRITE miss.
    issue(2'b10, 32'h204, 1'b0, 2'b00, 32'h0);
    serve("wr_miss", 2, 1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 32'h204, nreq);
    check("wr_miss_nreq", 64'(nreq), 64'd2);
    check_result("wr_miss", e);
    hold_release("wr_miss", e);

    // WRITE by the requesting core itself.
    issue(2'b10, 32'h208, 1'b1, 2'b00, 32'h0);
    check("wr_self_req", bus.cache_req_o, 1'b0);
    check_result("wr_self", e);
    hold_release("wr_self", e);

    // Timeout: no ack at all.
    issue(2'b01, 32'h300, 1'b0, 2'b00, 32'h0);
    serve("tmo", 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h300, nreq);
    check("tmo_nreq", 64'(nreq), 64'(TO));
    check_result("tmo", e);
    hold_release("tmo", e);

    // Ack on the final allowed cycle beats the timeout.
    issue(2'b01, 32'h304, 1'b0, 2'b11, 32'hCAFE_F00D);
    serve("tmo_ack", TO, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h304, nreq);
    check("tmo_ack_nreq", 64'(nreq), 64'(TO));
    check_result("tmo_ack", e);
    hold_release("tmo_ack", e);

    // Unused type 11 is ignored.
    bus.snoop_type_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t11_req", bus.cache_req_o, 1'b0);
      check("t11_resp", bus.snoop_response_o, 2'b10);
    end
    bus.snoop_type_i = 2'b00;
    step();

    // Abort: type drops during LOOKUP; handshake still completes, result discarded.
    issue(2'b01, 32'h400, 1'b0, 2'b10, 32'h0);
    check("abort_req", bus.cache_req_o, 1'b1);
    bus.snoop_type_i = 2'b00;
    serve("abort", 3, 1'b1, 1'b1, 32'h7777_7777, 1'b0, 32'h400, nreq);
    check("abort_nreq", 64'(nreq), 64'd3);
    check_result("abort", e);
    // Back in IDLE already: a new snoop is accepted immediately.
    issue(2'b01, 32'h404, 1'b0, 2'b00, 32'h0);
    check("post_abort_req", bus.cache_req_o, 1'b1);
    serve("post_abort", 1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h404, nreq);
    check_result("post_abort", e);
    hold_release("post_abort", e);

    // Asynchronous reset in the middle of a lookup.
    issue(2'b01, 32'h500, 1'b0, 2'b10, 32'h0);
    check("arst_req_before", bus.cache_req_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", bus.cache_req_o, 1'b0);
    check("arst_adr", bus.cache_adr_o, 32'h0);
    check_result("arst", e);
    idle_inputs();
    #2;
    rst = 1'b0;
    step();
    step();
    check("arst_idle_resp", bus.snoop_response_o, 2'b10);

    // Normal operation after reset.
    issue(2'b01, 32'h600, 1'b0, 2'b11, 32'h600D_600D);
    serve("recover", 1, 1'b1, 1'b1, 32'h600D_600D, 1'b0, 32'h600, nreq);
    check_result("recover", e);
    hold_release("recover", e);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
